fnd_watch_ctrl: RTL and testbench

//  Downstream display stage for the watch datapath. Takes msec/sec/min/hour

---
 rtl/fnd_watch_ctrl.sv | 153 +++++++++++++++
 tb/tb_fnd_watch_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_watch_ctrl.sv
// Time-multiplexed 4-digit common-anode 7-segment driver for the watch fields.
// Optional edit-field blinking is built only when FND_EDIT_BLINK_EN is defined.
module fnd_watch_ctrl #(
   parameter int unsigned SCAN_COUNT  = 100_000,
   parameter int unsigned BLINK_COUNT = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] msec,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   input  logic [4:0] hour,
   input  logic       sel_mode,
   input  logic [2:0] digit_pos,
   output logic [3:0] fnd_com,
   output logic [7:0] fnd_data
);

   localparam int unsigned ScanW = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;

   logic [ScanW-1:0] scan_cnt_q;
   logic             scan_tick;
   logic [1:0]       dig_idx_q;

   logic [6:0] snap_msec_q;
   logic [5:0] snap_sec_q;
   logic [5:0] snap_min_q;
   logic [4:0] snap_hour_q;
   logic       snap_mode_q;

   logic [6:0] low_val;
   logic [6:0] high_val;
   logic [6:0] cur_val;
   logic [3:0] cur_digit;
   logic       dp_on;
   logic       edit_blank;
   logic [7:0] seg_d;
   logic [3:0] com_d;

   function automatic logic [7:0] seg_code(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   assign scan_tick = (scan_cnt_q == ScanW'(SCAN_COUNT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt_q <= '0;
         dig_idx_q  <= 2'd0;
      end else if (scan_tick) begin
         scan_cnt_q <= '0;
         dig_idx_q  <= dig_idx_q + 2'd1;
      end else begin
         scan_cnt_q <= scan_cnt_q + ScanW'(1);
      end
   end

   // Fields are frozen per frame so a frame never mixes old and new values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         snap_msec_q <= '0;
         snap_sec_q  <= '0;
         snap_min_q  <= '0;
         snap_hour_q <= '0;
         snap_mode_q <= 1'b0;
      end else if (scan_tick && (dig_idx_q == 2'd3)) begin
         snap_msec_q <= msec;
         snap_sec_q  <= sec;
         snap_min_q  <= min;
         snap_hour_q <= hour;
         snap_mode_q <= sel_mode;
      end
   end

`ifdef FND_EDIT_BLINK_EN
   localparam int unsigned BlinkW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

   logic [BlinkW-1:0] blink_cnt_q;
   logic              blink_ph_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b1;
      end else if (blink_cnt_q == BlinkW'(BLINK_COUNT - 1)) begin
         blink_cnt_q <= '0;
         blink_ph_q  <= ~blink_ph_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + BlinkW'(1);
      end
   end

   // digit_pos is live; msec (mode0 low field) is never an edit target.
   always_comb begin
      edit_blank = 1'b0;
      if (!blink_ph_q) begin
         if (snap_mode_q) begin
            edit_blank = dig_idx_q[1] ? digit_pos[2] : digit_pos[1];
         end else begin
            edit_blank = dig_idx_q[1] & digit_pos[0];
         end
      end
   end
`else
   logic unused_digit_pos;
   assign unused_digit_pos = ^digit_pos;
   assign edit_blank       = 1'b0;
`endif

   always_comb begin
      low_val  = snap_mode_q ? {1'b0, snap_min_q}  : snap_msec_q;
      high_val = snap_mode_q ? {2'b0, snap_hour_q} : {1'b0, snap_sec_q};
      cur_val  = dig_idx_q[1] ? high_val : low_val;
      cur_digit = dig_idx_q[0] ? 4'(cur_val / 7'd10) : 4'(cur_val % 7'd10);
      // In hour.min mode the point flashes at 1 Hz off the msec field.
      dp_on = !snap_mode_q || (snap_msec_q < 7'd50);

      seg_d = (cur_val > 7'd99) ? 8'hBF : seg_code(cur_digit);
      if ((dig_idx_q == 2'd2) && dp_on) begin
         seg_d[7] = 1'b0;
      end
      if (edit_blank) begin
         seg_d = 8'hFF;
      end
      com_d = ~(4'b0001 << dig_idx_q);
   end

   // Outputs load the digit that dig_idx points at when its slot ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fnd_com  <= 4'b1111;
         fnd_data <= 8'hFF;
      end else if (scan_tick) begin
         fnd_com  <= com_d;
         fnd_data <= seg_d;
      end
   end

endmodule

// File: tb/tb_fnd_watch_ctrl.sv
// Directed bench for fnd_watch_ctrl with SCAN_COUNT=4, BLINK_COUNT=16.
module tb_fnd_watch_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] msec = '0;
   logic [5:0] sec = '0;
   logic [5:0] min = '0;
   logic [4:0] hour = '0;
   logic       sel_mode = 1'b0;
   logic [2:0] digit_pos = '0;
   logic [3:0] fnd_com;
   logic [7:0] fnd_data;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [15:0] ComSeq = 16'h7BDE;

   fnd_watch_ctrl #(
      .SCAN_COUNT (4),
      .BLINK_COUNT(16)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .msec     (msec),
      .sec      (sec),
      .min      (min),
      .hour     (hour),
      .sel_mode (sel_mode),
      .digit_pos(digit_pos),
      .fnd_com  (fnd_com),
      .fnd_data (fnd_data)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Leaves the bench at the first negedge after reset release.
   task automatic apply_reset(input logic m, input logic [4:0] h, input logic [5:0] mi,
                              input logic [5:0] s, input logic [6:0] ms,
                              input logic [2:0] pos);
      @(negedge clk);
      rst = 1'b1;
      sel_mode = m; hour = h; min = mi; sec = s; msec = ms; digit_pos = pos;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Samples one slot per digit; data packed {d3,d2,d1,d0}.
   task automatic grab_frame(output logic [31:0] data, output logic [15:0] com);
      for (int i = 0; i < 4; i++) begin
         step(4);
         data[8*i +: 8] = fnd_data;
         com[4*i +: 4]  = fnd_com;
      end
   endtask

   task automatic test_reset;
      logic [7:0] exp_d [4];
      exp_d[0] = 8'hC0; exp_d[1] = 8'hC0; exp_d[2] = 8'h40; exp_d[3] = 8'hC0;
      @(negedge clk);
      rst = 1'b1;
      sel_mode = 1'b0; hour = 5'd23; min = 6'd5; sec = 6'd42; msec = 7'd7; digit_pos = 3'b000;
      #1;
      n_checks++;
      if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL reset_hold: com=%b data=%h, required 1111/ff", fnd_com, fnd_data);
      end
      @(negedge clk);
      rst = 1'b0;
      step(3);
      n_checks++;
      if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL pre_first_tick: com=%b data=%h, required 1111/ff", fnd_com, fnd_data);
      end
      for (int i = 0; i < 4; i++) begin
         step(i == 0 ? 1 : 4);
         n_checks++;
         if (fnd_com !== ComSeq[4*i +: 4] || fnd_data !== exp_d[i]) begin
            n_fail++;
            $display("FAIL reset_frame_digit%0d: com=%b data=%h, required %b/%h",
                     i, fnd_com, fnd_data, ComSeq[4*i +: 4], exp_d[i]);
         end
      end
   endtask

   task automatic test_mode0;
      logic [31:0] d;
      logic [15:0] c;
      apply_reset(1'b0, 5'd0, 6'd0, 6'd42, 7'd7, 3'b000);
      grab_frame(d, c);
      grab_frame(d, c);
      n_checks++;
      if (d !== 32'h9924C0F8 || c !== ComSeq) begin
         n_fail++;
         $display("FAIL mode0_frame1: data=%h com=%h, required 9924c0f8/%h", d, c, ComSeq);
      end
      sec = 6'd15; msec = 7'd39;
      grab_frame(d, c);
      n_checks++;
      if (d !== 32'h9924C0F8) begin
         n_fail++;
         $display("FAIL mode0_no_tear: data=%h, required 9924c0f8", d);
      end
      grab_frame(d, c);
      n_checks++;
      if (d !== 32'hF912B090) begin
         n_fail++;
         $display("FAIL mode0_update: data=%h, required f912b090", d);
      end
   endtask

   task automatic test_mode1;
      logic [31:0] d;
      logic [15:0] c;
      apply_reset(1'b1, 5'd23, 6'd5, 6'd0, 7'd60, 3'b000);
      grab_frame(d, c);
      grab_frame(d, c);
      n_checks++;
      if (d !== 32'hA4B0C092 || c !== ComSeq) begin
         n_fail++;
         $display("FAIL mode1_dp_off: data=%h com=%h, required a4b0c092/%h", d, c, ComSeq);
      end
      msec = 7'd10;
      grab_frame(d, c);
      grab_frame(d, c);
      n_checks++;
      if (d !== 32'hA430C092) begin
         n_fail++;
         $display("FAIL mode1_dp_on: data=%h, required a430c092", d);
      end
   endtask

   task automatic test_mode_switch;
      logic [31:0] d;
      logic [15:0] c;
      apply_reset(1'b0, 5'd0, 6'd0, 6'd42, 7'd7, 3'b000);
      grab_frame(d, c);
      step(8);
      sel_mode = 1'b1; hour = 5'd23; min = 6'd5;
      step(4);
      n_checks++;
      if (fnd_com !== 4'b1011 || fnd_data !== 8'h24) begin
         n_fail++;
         $display("FAIL switch_digit2_old: com=%b data=%h, required 1011/24", fnd_com, fnd_data);
      end
      step(4);
      n_checks++;
      if (fnd_com !== 4'b0111 || fnd_data !== 8'h99) begin
         n_fail++;
         $display("FAIL switch_digit3_old: com=%b data=%h, required 0111/99", fnd_com, fnd_data);
      end
      grab_frame(d, c);
      n_checks++;
      if (d !== 32'hA430C092) begin
         n_fail++;
         $display("FAIL switch_next_frame: data=%h, required a430c092", d);
      end
   endtask

   task automatic test_dash;
      logic [31:0] d;
      logic [15:0] c;
      apply_reset(1'b0, 5'd0, 6'd0, 6'd59, 7'd120, 3'b000);
      grab_frame(d, c);
      grab_frame(d, c);
      n_checks++;
      if (d !== 32'h9210BFBF) begin
         n_fail++;
         $display("FAIL dash_msec_over_99: data=%h, required 9210bfbf", d);
      end
   endtask

   task automatic test_blink;
      logic [31:0] d;
      logic [15:0] c;
      logic [31:0] exp1;
      logic [31:0] exp3;
`ifdef FND_EDIT_BLINK_EN
      exp1 = 32'hFFFFC092;
      exp3 = 32'hA4B0FFFF;
`else
      exp1 = 32'hA4B0C092;
      exp3 = 32'hA4B0C092;
`endif
      apply_reset(1'b1, 5'd23, 6'd5, 6'd0, 7'd60, 3'b100);
      grab_frame(d, c);
      grab_frame(d, c);
      n_checks++;
      if (d !== exp1) begin
         n_fail++;
         $display("FAIL blink_hour_phase0: data=%h, required %h", d, exp1);
      end
      grab_frame(d, c);
      n_checks++;
      if (d !== 32'hA4B0C092) begin
         n_fail++;
         $display("FAIL blink_hour_phase1: data=%h, required a4b0c092", d);
      end
      digit_pos = 3'b010;
      grab_frame(d, c);
      n_checks++;
      if (d !== exp3) begin
         n_fail++;
         $display("FAIL blink_min_live_pos: data=%h, required %h", d, exp3);
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      logic [15:0] c;
      apply_reset(1'b0, 5'd0, 6'd0, 6'd42, 7'd7, 3'b000);
      grab_frame(d, c);
      grab_frame(d, c);
      step(8);
      n_checks++;
      if (fnd_com !== 4'b1101 || fnd_data !== 8'hC0) begin
         n_fail++;
         $display("FAIL midframe_before_rst: com=%b data=%h, required 1101/c0", fnd_com, fnd_data);
      end
      step(2);
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL async_reset: com=%b data=%h, required 1111/ff", fnd_com, fnd_data);
      end
      @(negedge clk);
      rst = 1'b0;
      step(3);
      n_checks++;
      if (fnd_com !== 4'b1111 || fnd_data !== 8'hFF) begin
         n_fail++;
         $display("FAIL rst_restart_idle: com=%b data=%h, required 1111/ff", fnd_com, fnd_data);
      end
      step(1);
      n_checks++;
      if (fnd_com !== 4'b1110 || fnd_data !== 8'hC0) begin
         n_fail++;
         $display("FAIL rst_restart_digit0: com=%b data=%h, required 1110/c0", fnd_com, fnd_data);
      end
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_mode1();
      test_mode_switch();
      test_dash();
      test_blink();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
